openfire_dmem_lsu: RTL and testbench
====================================

// Module: openfire_dmem_lsu
// PURPOSE
//  Data-memory load/store unit between EXECUTE and the data bus; sits directly upstream of the regfile DMEM port.
//  Big-endian (MicroBlaze) lane steering: loads are returned MSB-justified, so the regfile's
//   byte, halfword and word selects take [31:24], [31:16] and [31:0].
//  Stores are replicated with byte enables. Pipeline stalls until the bus acks, times out or the access is rejected.
// PARAMETERS
//  ADDR_W     18   byte-address width (= `A_SPACE+2)
//  TIMEOUT    255  wait-state cycles before bus error; 0 = never time out
// PORTS
//  clock       in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high
//  req_load    in   1       EXECUTE: load request, held while stall=1
//  req_store   in   1       EXECUTE: store request, held while stall=1
//  req_size    in   2       00 byte, 01 halfword, 10 word, 11 illegal
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data, LSB-justified
//  stall       out  1       freeze pipeline
//  dmem_data   out  32      MSB-justified load data to regfile
//  we_load     out  1       one-cycle regfile write strobe for a completed load
//  unaligned   out  1       one-cycle pulse: misaligned or illegal-size request
//  bus_err     out  1       one-cycle pulse: timeout
//  dbus_addr   out  ADDR_W  word-aligned address, [1:0]=0
//  dbus_rd     out  1       read strobe, held until ack
//  dbus_wr     out  1       write strobe, held until ack
//  dbus_be     out  4       byte enables; be[3] = bits [31:24] = byte offset 0
//  dbus_wdata  out  32      replicated store data
//  dbus_rdata  in   32      read data, valid with ack
//  dbus_ack    in   1       completion, one cycle
// BEHAVIOUR
//  Reset: state IDLE.
//   All registered outputs 0: dbus_*, dmem_data, we_load, unaligned, bus_err.
//   stall=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE
//   - Request = req_load|req_store. If both are set, treat it as a load.
//   - Misaligned means: size 11, half with addr[0]=1, or word with addr[1:0]!=0.
//   - Misaligned request: unaligned=1 next cycle, no bus access, stall=0, stay IDLE.
//   - Valid request: stall=1 combinationally the same cycle.
//     Register addr/size/offset/type; set dbus_rd or dbus_wr; go BUSY.
//  BUSY
//   - stall=1; bus outputs held constant.
//   - Wait counter increments each cycle without ack.
//   - On dbus_ack: capture and steer rdata; drop strobes; go DONE.
//   - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack: drop strobes; go DONE with error flag.
//  DONE (one cycle)
//   - stall=0.
//   - Load: we_load=1.
//   - Error: bus_err=1, we_load=0, dmem_data=0.
//   - Always return to IDLE. Any request present in DONE is the stale one and is ignored; a new request is seen next cycle.
//  Latency: request cycle N, strobe at N+1. Earliest ack N+1 -> DONE at N+2, stall high N..N+1.
//  Load steering (o = addr[1:0]), unused dmem_data bits = 0:
//   - byte: dmem_data[31:24] = rdata[31-8o -: 8]
//   - half: dmem_data[31:16] = o[1] ? rdata[15:0] : rdata[31:16]
//   - word: dmem_data = rdata
//  Store steering:
//   - byte: wdata={4{d[7:0]}}, be=4'b1000>>o
//   - half: wdata={2{d[15:0]}}, be = o[1] ? 0011 : 1100
//   - word: wdata=d, be=1111
//  dbus_ack in IDLE or DONE is ignored.
//  Reset mid-access: strobes drop at that edge, no we_load, and no error pulse.
// STRUCTURE
//  openfire_define.v gets these shared constants:
//   - `LSU_BYTE, `LSU_HALF, `LSU_WORD
//   - state encodings `LSU_IDLE, `LSU_BUSY, `LSU_DONE
//  Sub-module openfire_lsu_steer: purely combinational lane steering for both directions (size, offset -> be/wdata/rdata).
//  The top level holds the FSM, timeout counter and bus registers.
// TESTING
//  1. Byte load at addr 0x0003, rdata=0x11223344, ack one cycle after strobe
//     -> dmem_data=0x44000000, we_load once, stall exactly 2 cycles.
//  2. Half store at addr 0x0102, d=0x0000BEEF
//     -> dbus_addr=0x0100, be=0011, wdata=0xBEEFBEEF, we_load never.
//  3. Word load at addr 0x0002
//     -> unaligned pulse, no dbus_rd, stall never high.
//  4. TIMEOUT=4, no ack -> strobe held 4 cycles, then bus_err pulse, we_load=0, back to IDLE.
//  5. Reset asserted during BUSY with 3 wait states -> next cycle all outputs 0; a late ack is ignored.
//  6. Back-to-back word loads at 0x10 and 0x14, ack 2 cycles after strobe
//     -> two we_load pulses, the second strobe starts the cycle after DONE.

Source files
------------

// File: rtl/openfire_dmem_lsu_pkg.sv
// Shared constants, FSM state type and request-legality helper for the
// OpenFire data-memory load/store unit.
package openfire_dmem_lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Size 2'b11 is illegal and is reported the same way as a misalignment.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            LSU_BYTE: bad = 1'b0;
            LSU_HALF: bad = off[0];
            LSU_WORD: bad = (off != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/openfire_dmem_lsu_if.sv
// EXECUTE-side request/response and data-bus signals of the LSU.
// The LSU connects through the slave modport; its environment uses master.
interface openfire_dmem_lsu_if #(
    parameter int ADDR_W = 18
);
    logic              req_load;
    logic              req_store;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic [31:0]       dmem_data;
    logic              we_load;
    logic              unaligned;
    logic              bus_err;
    logic [ADDR_W-1:0] dbus_addr;
    logic              dbus_rd;
    logic              dbus_wr;
    logic [3:0]        dbus_be;
    logic [31:0]       dbus_wdata;
    logic [31:0]       dbus_rdata;
    logic              dbus_ack;

    modport slave (
        input  req_load, req_store, req_size, req_addr, req_wdata,
        input  dbus_rdata, dbus_ack,
        output stall, dmem_data, we_load, unaligned, bus_err,
        output dbus_addr, dbus_rd, dbus_wr, dbus_be, dbus_wdata
    );

    modport master (
        output req_load, req_store, req_size, req_addr, req_wdata,
        output dbus_rdata, dbus_ack,
        input  stall, dmem_data, we_load, unaligned, bus_err,
        input  dbus_addr, dbus_rd, dbus_wr, dbus_be, dbus_wdata
    );

endinterface

// File: rtl/openfire_dmem_lsu_steer.sv
// Combinational big-endian lane steering: store data replication with byte
// enables, and MSB-justified extraction of load data.
module openfire_dmem_lsu_steer
    import openfire_dmem_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    always_comb begin
        be_o      = '0;
        wdata_o   = '0;
        ld_data_o = '0;
        case (size_i)
            LSU_BYTE: begin
                be_o               = 4'b1000 >> off_i;
                wdata_o            = {4{st_data_i[7:0]}};
                // Byte offset 0 lives in bits [31:24].
                ld_data_o[31:24]   = ld_data_i[(5'd24 - {off_i, 3'b000}) +: 8];
            end
            LSU_HALF: begin
                be_o               = off_i[1] ? 4'b0011 : 4'b1100;
                wdata_o            = {2{st_data_i[15:0]}};
                ld_data_o[31:16]   = off_i[1] ? ld_data_i[15:0] : ld_data_i[31:16];
            end
            LSU_WORD: begin
                be_o               = 4'b1111;
                wdata_o            = st_data_i;
                ld_data_o          = ld_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/openfire_dmem_lsu.sv
// OpenFire data-memory load/store unit: IDLE/BUSY/DONE bus sequencer with
// wait-state timeout, registered bus outputs and regfile load return.
module openfire_dmem_lsu
    import openfire_dmem_lsu_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int TIMEOUT = 255
) (
    input logic                clock,
    input logic                reset,
    openfire_dmem_lsu_if.slave lsu
);

    localparam int TMAX  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int CNT_W = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              load_q, load_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       dmem_q, dmem_d;
    logic              we_q, we_d;
    logic              unal_q, unal_d;
    logic              berr_q, berr_d;
    logic              stall_c;

    logic [1:0]        steer_size, steer_off;
    logic [3:0]        steer_be;
    logic [31:0]       steer_wdata, steer_ld;
    logic              req, req_bad;

    // Stores are steered from the live request in IDLE; loads from the captured request in BUSY.
    assign steer_size = (state_q == LSU_IDLE) ? lsu.req_size : size_q;
    assign steer_off  = (state_q == LSU_IDLE) ? lsu.req_addr[1:0] : off_q;

    openfire_dmem_lsu_steer u_steer (
        .size_i    (steer_size),
        .off_i     (steer_off),
        .st_data_i (lsu.req_wdata),
        .ld_data_i (lsu.dbus_rdata),
        .be_o      (steer_be),
        .wdata_o   (steer_wdata),
        .ld_data_o (steer_ld)
    );

    assign req     = lsu.req_load | lsu.req_store;
    assign req_bad = lsu_misaligned(lsu.req_size, lsu.req_addr[1:0]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        off_d   = off_q;
        load_d  = load_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        dmem_d  = dmem_q;
        we_d    = 1'b0;
        unal_d  = 1'b0;
        berr_d  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (req && req_bad) begin
                    unal_d = 1'b1;
                end else if (req) begin
                    stall_c = 1'b1;
                    addr_d  = {lsu.req_addr[ADDR_W-1:2], 2'b00};
                    size_d  = lsu.req_size;
                    off_d   = lsu.req_addr[1:0];
                    load_d  = lsu.req_load;
                    rd_d    = lsu.req_load;
                    wr_d    = ~lsu.req_load;
                    be_d    = steer_be;
                    wdata_d = lsu.req_load ? 32'h0 : steer_wdata;
                    cnt_d   = '0;
                    state_d = LSU_BUSY;
                end
            end
            LSU_BUSY: begin
                stall_c = 1'b1;
                if (lsu.dbus_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    we_d    = load_q;
                    if (load_q) dmem_d = steer_ld;
                    state_d = LSU_DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TMAX)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    berr_d  = 1'b1;
                    dmem_d  = 32'h0;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Any request seen here is the one just serviced.
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            off_q   <= '0;
            load_q  <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            dmem_q  <= '0;
            we_q    <= 1'b0;
            unal_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            off_q   <= off_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            dmem_q  <= dmem_d;
            we_q    <= we_d;
            unal_q  <= unal_d;
            berr_q  <= berr_d;
        end
    end

    assign lsu.stall      = stall_c;
    assign lsu.dmem_data  = dmem_q;
    assign lsu.we_load    = we_q;
    assign lsu.unaligned  = unal_q;
    assign lsu.bus_err    = berr_q;
    assign lsu.dbus_addr  = addr_q;
    assign lsu.dbus_rd    = rd_q;
    assign lsu.dbus_wr    = wr_q;
    assign lsu.dbus_be    = be_q;
    assign lsu.dbus_wdata = wdata_q;

endmodule

// File: tb/tb_openfire_dmem_lsu.sv
// Directed and randomized bench for openfire_dmem_lsu against a byte-lane
// arithmetic reference model of big-endian load/store behaviour.
module tb_openfire_dmem_lsu;
    import openfire_dmem_lsu_pkg::*;

    localparam int ADDR_W  = 18;
    localparam int TIMEOUT = 4;
    localparam int NO_ACK  = 99;

    logic clock = 1'b0;
    logic reset;

    openfire_dmem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

    openfire_dmem_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .lsu   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_load(input logic [1:0] sz, input int o, input logic [31:0] r);
        case (sz)
            2'd0:    return ((r >> (8 * (3 - o))) & 32'hFF) << 24;
            2'd1:    return ((r >> (16 * (1 - o / 2))) & 32'hFFFF) << 16;
            default: return r;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input int o);
        case (sz)
            2'd0:    return 4'(1 << (3 - o));
            2'd1:    return (o >= 2) ? 4'h3 : 4'hC;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    return (d & 32'hFF) * 32'h01010101;
            2'd1:    return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic bit m_bad(input logic [1:0] sz, input int o);
        return (sz == 2'd3) || (sz == 2'd1 && (o % 2) != 0) || (sz == 2'd2 && o != 0);
    endfunction

    // Entered and left just after a rising edge; dly = wait cycles before ack.
    task automatic access(input bit ld, input bit st, input logic [1:0] sz,
                          input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int dly, output int stalls);
        bit   is_ld, bad, err, done;
        int   o;
        is_ld = ld;
        o     = int'(a) % 4;
        bad   = m_bad(sz, o);
        err   = (dly >= TIMEOUT);
        stalls = 0;
        bus.req_load  = ld;
        bus.req_store = st;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(negedge clock);
        check("req_outputs", {27'b0, bus.we_load, bus.bus_err, bus.unaligned, bus.dbus_rd, bus.dbus_wr}, 32'h0);
        check("req_stall", {31'b0, bus.stall}, {31'b0, !bad});
        stalls += int'(bus.stall);
        @(posedge clock); #1;
        if (bad) begin
            bus.req_load  = 1'b0;
            bus.req_store = 1'b0;
            @(negedge clock);
            check("unaligned_pulse", {31'b0, bus.unaligned}, 32'h1);
            check("unaligned_nobus", {29'b0, bus.stall, bus.dbus_rd, bus.dbus_wr}, 32'h0);
            @(posedge clock); #1;
            return;
        end
        done = 1'b0;
        for (int c = 0; c < TIMEOUT && !done; c++) begin
            if (c == dly) begin
                bus.dbus_ack   = 1'b1;
                bus.dbus_rdata = rd;
            end
            @(negedge clock);
            check("busy_strobe", {30'b0, bus.dbus_rd, bus.dbus_wr}, is_ld ? 32'h2 : 32'h1);
            check("busy_addr", 32'(bus.dbus_addr), 32'(a) & ~32'h3);
            check("busy_stall", {31'b0, bus.stall}, 32'h1);
            if (!is_ld) begin
                check("busy_be", {28'b0, bus.dbus_be}, {28'b0, m_be(sz, o)});
                check("busy_wdata", bus.dbus_wdata, m_wdata(sz, wd));
            end
            stalls += int'(bus.stall);
            @(posedge clock); #1;
            bus.dbus_ack   = 1'b0;
            bus.dbus_rdata = $urandom();
            if (c == dly || c == TIMEOUT - 1) done = 1'b1;
        end
        // The request stays asserted through DONE and must be ignored there.
        @(negedge clock);
        check("done_stall_strobe", {29'b0, bus.stall, bus.dbus_rd, bus.dbus_wr}, 32'h0);
        check("done_we_load", {31'b0, bus.we_load}, {31'b0, is_ld && !err});
        check("done_bus_err", {31'b0, bus.bus_err}, {31'b0, err});
        if (is_ld) check("done_dmem", bus.dmem_data, err ? 32'h0 : m_load(sz, o, rd));
        @(posedge clock); #1;
        bus.req_load  = 1'b0;
        bus.req_store = 1'b0;
    endtask

    initial begin
        int stalls;
        bit ld, st;
        int dsel;
        reset          = 1'b1;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.dbus_rdata = '0;
        bus.dbus_ack   = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_ctrl", {26'b0, bus.stall, bus.we_load, bus.unaligned, bus.bus_err, bus.dbus_rd, bus.dbus_wr}, 32'h0);
        check("reset_bus", {bus.dbus_be, 10'(bus.dbus_addr), 18'b0} | bus.dbus_wdata | bus.dmem_data, 32'h0);
        @(posedge clock); #1;

        // Byte load at offset 3, acked in the first strobe cycle
        access(1, 0, LSU_BYTE, 18'h00003, 32'h0, 32'h11223344, 0, stalls);
        check("byte_load_stall_cycles", 32'(stalls), 32'd2);

        // Half store at 0x0102
        access(0, 1, LSU_HALF, 18'h00102, 32'h0000BEEF, 32'h0, 0, stalls);

        // Misaligned word load
        access(1, 0, LSU_WORD, 18'h00002, 32'h0, 32'h0, 0, stalls);
        check("unaligned_stall_cycles", 32'(stalls), 32'd0);

        // Timeout: strobe held TIMEOUT cycles then bus error
        access(1, 0, LSU_WORD, 18'h00040, 32'h0, 32'hCAFEF00D, NO_ACK, stalls);
        check("timeout_strobe_cycles", 32'(stalls - 1), 32'(TIMEOUT));

        // Reset during BUSY after 3 wait states, then a late ack
        bus.req_load = 1'b1;
        bus.req_size = LSU_WORD;
        bus.req_addr = 18'h00020;
        @(posedge clock); #1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset         = 1'b1;
        bus.req_load  = 1'b0;
        @(posedge clock); #1;
        reset          = 1'b0;
        bus.dbus_ack   = 1'b1;
        bus.dbus_rdata = 32'hDEADBEEF;
        @(negedge clock);
        check("midreset_ctrl", {26'b0, bus.stall, bus.we_load, bus.unaligned, bus.bus_err, bus.dbus_rd, bus.dbus_wr}, 32'h0);
        check("midreset_bus", {bus.dbus_be, 10'(bus.dbus_addr), 18'b0} | bus.dbus_wdata | bus.dmem_data, 32'h0);
        @(posedge clock); #1;
        bus.dbus_ack = 1'b0;
        @(negedge clock);
        check("late_ack_ignored", {28'b0, bus.we_load, bus.bus_err, bus.dbus_rd, bus.dbus_wr}, 32'h0);
        check("late_ack_dmem", bus.dmem_data, 32'h0);
        @(posedge clock); #1;

        // Back-to-back word loads
        access(1, 0, LSU_WORD, 18'h00010, 32'h0, 32'hA1B2C3D4, 1, stalls);
        access(1, 0, LSU_WORD, 18'h00014, 32'h0, 32'h55667788, 1, stalls);
        check("b2b_second_stall_cycles", 32'(stalls), 32'd3);

        // Load and store both requested: treated as a load
        access(1, 1, LSU_HALF, 18'h00202, 32'h12345678, 32'h9ABCDEF0, 0, stalls);

        for (int i = 0; i < 40; i++) begin
            ld   = 1'($urandom_range(0, 1));
            st   = ld ? 1'($urandom_range(0, 1)) : 1'b1;
            dsel = int'($urandom_range(0, 4));
            access(ld, st, 2'($urandom_range(0, 3)), 18'($urandom()), $urandom(), $urandom(),
                   (dsel == 4) ? NO_ACK : dsel, stalls);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
